// File: rtl/mainmem_backdoor_port.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mainmem_backdoor_port : FIFO-buffered 64-bit backdoor into a scratchpad    |
// | Optional window check: MAINMEM_BACKDOOR_WINDOW_CHECK_EN    Rev 1.0         |
// +--------------------------------------------------------------------------+
module mainmem_backdoor_port #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] WIN_BASE   = 32'h0000_0000,
  parameter logic [31:0] WIN_SIZE   = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_write,
  output logic        rsp_err,
  input  logic        mem_rst,
  output logic        mem_write_o,
  output logic [7:0]  mem_mask_o,
  output logic [31:0] mem_addr_o,
  output logic [63:0] mem_wdata_o,
  input  logic [63:0] mem_rdata_i,
  output logic        busy
);

  localparam int unsigned   c_aw    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned   c_cw    = c_aw + 1;
  localparam logic [c_cw-1:0] c_depth = c_cw'(FIFO_DEPTH);

  localparam logic [1:0] c_s_idle   = 2'd0;
  localparam logic [1:0] c_s_issue  = 2'd1;
  localparam logic [1:0] c_s_rdwait = 2'd2;
  localparam logic [1:0] c_s_resp   = 2'd3;

  logic [28:0]     r_fifo_addr  [FIFO_DEPTH];
  logic [63:0]     r_fifo_wdata [FIFO_DEPTH];
  logic            r_fifo_write [FIFO_DEPTH];
  logic [c_aw-1:0] r_wr_ptr;
  logic [c_aw-1:0] r_rd_ptr;
  logic [c_cw-1:0] r_count;
  logic [1:0]      r_state;
  logic [63:0]     r_rsp_rdata;
  logic            r_rsp_write;
  logic            r_rsp_err;

  logic [1:0]  w_state_nxt;
  logic        w_push;
  logic        w_pop;
  logic        w_empty;
  logic        w_full;
  logic [28:0] w_head_addr;
  logic [63:0] w_head_wdata;
  logic        w_head_write;
  logic        w_head_in_win;
  logic        w_in_access;
  logic        w_mem_wr;
  logic        w_unused_lsb;

  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == c_depth);
  assign req_ready    = !rst && !w_full;
  assign w_push       = req_valid && req_ready;
  assign w_head_addr  = r_fifo_addr[r_rd_ptr];
  assign w_head_wdata = r_fifo_wdata[r_rd_ptr];
  assign w_head_write = r_fifo_write[r_rd_ptr];
  assign w_unused_lsb = ^req_addr[2:0];

`ifdef MAINMEM_BACKDOOR_WINDOW_CHECK_EN
  logic [32:0] w_head_byte;
  // 33-bit compare so a window ending at 4 GiB does not wrap
  assign w_head_byte   = {1'b0, w_head_addr, 3'b000};
  assign w_head_in_win = (w_head_byte >= {1'b0, WIN_BASE}) &&
                         (w_head_byte < ({1'b0, WIN_BASE} + {1'b0, WIN_SIZE}));
`else
  logic w_unused_win;
  assign w_unused_win  = ^{WIN_BASE, WIN_SIZE};
  assign w_head_in_win = 1'b1;
`endif

  // Head entry stays in the FIFO until the response is formed, so an access
  // abandoned by mem_rst can simply be re-issued from IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      c_s_idle: begin
        if (!w_empty && !mem_rst) begin
          if (w_head_in_win) begin
            w_state_nxt = c_s_issue;
          end else begin
            w_state_nxt = c_s_resp;
            w_pop       = 1'b1;
          end
        end
      end
      c_s_issue: begin
        if (mem_rst) begin
          w_state_nxt = c_s_idle;
        end else if (w_head_write) begin
          w_state_nxt = c_s_resp;
          w_pop       = 1'b1;
        end else begin
          w_state_nxt = c_s_rdwait;
        end
      end
      c_s_rdwait: begin
        if (mem_rst) begin
          w_state_nxt = c_s_idle;
        end else begin
          w_state_nxt = c_s_resp;
          w_pop       = 1'b1;
        end
      end
      c_s_resp: begin
        if (rsp_ready) begin
          w_state_nxt = c_s_idle;
        end
      end
      default: w_state_nxt = c_s_idle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr]  <= req_addr[31:3];
      r_fifo_wdata[r_wr_ptr] <= req_wdata;
      r_fifo_write[r_wr_ptr] <= req_write;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= c_s_idle;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_rsp_rdata <= '0;
      r_rsp_write <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
      if (w_pop) begin
        r_rsp_write <= w_head_write;
        r_rsp_err   <= !w_head_in_win;
        r_rsp_rdata <= (r_state == c_s_rdwait) ? mem_rdata_i : 64'd0;
      end
    end
  end

  assign w_in_access = (r_state == c_s_issue) || (r_state == c_s_rdwait);
  assign w_mem_wr    = (r_state == c_s_issue) && w_head_write;

  assign mem_write_o = w_mem_wr;
  assign mem_mask_o  = {8{w_mem_wr}};
  assign mem_addr_o  = w_in_access ? {w_head_addr, 3'b000} : 32'd0;
  assign mem_wdata_o = w_mem_wr ? w_head_wdata : 64'd0;

  assign rsp_valid = (r_state == c_s_resp);
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_write = r_rsp_write;
  assign rsp_err   = r_rsp_err;
  assign busy      = !w_empty || (r_state != c_s_idle);

endmodule
`default_nettype wire
